// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - state encoding and default geometry for the frame sequencer
package frame_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } seq_state_e;

    localparam int DEF_COLS   = 64;
    localparam int DEF_ROWS   = 64;
    localparam int DEF_HBLANK = 16;
    localparam int DEF_VBLANK = 8;
    localparam int DEF_CW     = 7;
    localparam int DEF_FW     = 8;

endpackage

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - CW-bit counter with clear, enable and terminal-count flag at a programmable bound
module seq_counter #(
    parameter int CW = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] bound_i,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] next_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q, count_d;

    assign tc_o = (count_q == bound_i - CW'(1));

    // Enabled at the terminal count reloads 0, so the count never passes its bound
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign next_o  = count_d;

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - camera frame timing controller; PIX_PATTERN_EN enables the pixel test pattern
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int HBLANK = DEF_HBLANK,
    parameter int VBLANK = DEF_VBLANK,
    parameter int CW     = DEF_CW,
    parameter int FW     = DEF_FW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          cont_i,
    input  logic          stop_i,
    output logic          busy_o,
    output logic          pix_valid_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          frame_done_o,
    output logic [FW-1:0] frame_cnt_o,
    output logic [7:0]    pix_data_o
);

    seq_state_e    state_q, state_d;
    logic          stop_pend_q, stop_pend_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          pix_valid_q, pix_valid_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_done_q, frame_done_d;

    logic          x_clr, x_en, x_tc;
    logic          y_clr, y_en, y_tc;
    logic          b_clr, b_en, b_tc;
    logic [CW-1:0] x_next, y_next, b_next, b_cnt, b_bound;

    assign b_bound = (state_q == ST_HBLANK) ? CW'(HBLANK) : CW'(VBLANK);

    seq_counter #(.CW(CW)) u_x_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(x_clr), .en_i(x_en),
        .bound_i(CW'(COLS)), .count_o(x_o), .next_o(x_next), .tc_o(x_tc)
    );

    seq_counter #(.CW(CW)) u_y_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(y_clr), .en_i(y_en),
        .bound_i(CW'(ROWS)), .count_o(y_o), .next_o(y_next), .tc_o(y_tc)
    );

    seq_counter #(.CW(CW)) u_blank_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(b_clr), .en_i(b_en),
        .bound_i(b_bound), .count_o(b_cnt), .next_o(b_next), .tc_o(b_tc)
    );

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        x_clr       = 1'b0;
        x_en        = 1'b0;
        y_clr       = 1'b0;
        y_en        = 1'b0;
        b_clr       = 1'b0;
        b_en        = 1'b0;
        if (state_q != ST_IDLE) begin
            stop_pend_d = stop_pend_q | stop_i;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_ACTIVE;
                    stop_pend_d = stop_i;
                    x_clr       = 1'b1;
                    y_clr       = 1'b1;
                    b_clr       = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (x_tc) begin
                    state_d = ST_HBLANK;
                end else begin
                    x_en = 1'b1;
                end
            end
            ST_HBLANK: begin
                b_en = 1'b1;
                if (b_tc) begin
                    if (y_tc) begin
                        state_d = ST_VBLANK;
                    end else begin
                        state_d = ST_ACTIVE;
                        x_clr   = 1'b1;
                        y_en    = 1'b1;
                    end
                end
            end
            ST_VBLANK: begin
                b_en = 1'b1;
                if (b_tc) begin
                    x_clr = 1'b1;
                    y_clr = 1'b1;
                    // A stop arriving on the very last cycle still ends the run here
                    if (cont_i && !(stop_pend_q || stop_i)) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pix_valid_d   = (state_d == ST_ACTIVE);
        line_start_d  = pix_valid_d && (x_next == '0);
        frame_start_d = line_start_d && (y_next == '0);
        hsync_d       = (state_d == ST_HBLANK);
        vsync_d       = (state_d == ST_VBLANK);
        frame_done_d  = vsync_d && (b_next == CW'(VBLANK - 1));
        frame_cnt_d   = frame_cnt_q + FW'(frame_done_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            stop_pend_q   <= 1'b0;
            frame_cnt_q   <= '0;
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            stop_pend_q   <= stop_pend_d;
            frame_cnt_q   <= frame_cnt_d;
            pix_valid_q   <= pix_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_done_q  <= frame_done_d;
        end
    end

`ifdef PIX_PATTERN_EN
    logic [7:0] pix_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_data_q <= 8'h00;
        end else begin
            pix_data_q <= pix_valid_d ? ({x_next[3:0], y_next[3:0]} ^ 8'(frame_cnt_d)) : 8'h00;
        end
    end

    assign pix_data_o = pix_data_q;
`else
    assign pix_data_o = 8'h00;
`endif

    assign busy_o        = (state_q != ST_IDLE);
    assign pix_valid_o   = pix_valid_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_done_o  = frame_done_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer; follows PIX_PATTERN_EN like the design
module tb_frame_sequencer;

    localparam int COLS      = 4;
    localparam int ROWS      = 3;
    localparam int HB        = 2;
    localparam int VB        = 3;
    localparam int CW        = 7;
    localparam int LINE_LEN  = COLS + HB;
    localparam int FRAME_LEN = ROWS * LINE_LEN + VB;

`ifdef PIX_PATTERN_EN
    localparam logic [7:0] PD_X3Y2 = 8'h32;
`else
    localparam logic [7:0] PD_X3Y2 = 8'h00;
`endif

    typedef struct packed {
        logic       busy;
        logic       pv;
        logic [6:0] x;
        logic [6:0] y;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       fd;
        logic [7:0] fc;
        logic [7:0] pd;
    } out_t;

    typedef struct {
        logic start;
        logic cont;
        logic stop;
        out_t exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          stop = 1'b0;
    logic          busy, pix_valid, line_start, frame_start, hsync, vsync, frame_done;
    logic [CW-1:0] x, y;
    logic [7:0]    frame_cnt, pix_data;
    logic          b2_busy, b2_pv, b2_ls, b2_fs, b2_hs, b2_vs, b2_fd;
    logic [CW-1:0] b2_x, b2_y;
    logic [1:0]    b2_fc;
    logic [7:0]    b2_pd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    frame_sequencer #(.COLS(COLS), .ROWS(ROWS), .HBLANK(HB), .VBLANK(VB), .CW(CW), .FW(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont), .stop_i(stop),
        .busy_o(busy), .pix_valid_o(pix_valid), .x_o(x), .y_o(y),
        .line_start_o(line_start), .frame_start_o(frame_start),
        .hsync_o(hsync), .vsync_o(vsync), .frame_done_o(frame_done),
        .frame_cnt_o(frame_cnt), .pix_data_o(pix_data)
    );

    // Narrow frame counter copy, driven identically, to exercise wrap-around
    frame_sequencer #(.COLS(COLS), .ROWS(ROWS), .HBLANK(HB), .VBLANK(VB), .CW(CW), .FW(2)) dut_fw2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont), .stop_i(stop),
        .busy_o(b2_busy), .pix_valid_o(b2_pv), .x_o(b2_x), .y_o(b2_y),
        .line_start_o(b2_ls), .frame_start_o(b2_fs),
        .hsync_o(b2_hs), .vsync_o(b2_vs), .frame_done_o(b2_fd),
        .frame_cnt_o(b2_fc), .pix_data_o(b2_pd)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic s, input logic c, input logic p);
        start = s;
        cont  = c;
        stop  = p;
        @(posedge clk);
        #1;
    endtask

    function automatic out_t observe();
        out_t o;
        o.busy = busy;       o.pv = pix_valid;
        o.x    = x;          o.y  = y;
        o.ls   = line_start; o.fs = frame_start;
        o.hs   = hsync;      o.vs = vsync;
        o.fd   = frame_done; o.fc = frame_cnt;
        o.pd   = pix_data;
        return o;
    endfunction

    // Expected outputs at cycle k of a frame, derived from line/column arithmetic
    function automatic out_t exp_at(input int k, input int f);
        out_t e;
        int   line, c;
        e      = '0;
        e.busy = 1'b1;
        e.fc   = 8'(f);
        if (k < ROWS * LINE_LEN) begin
            line = k / LINE_LEN;
            c    = k % LINE_LEN;
            e.y  = 7'(line);
            if (c < COLS) begin
                e.pv = 1'b1;
                e.x  = 7'(c);
                e.ls = (c == 0);
                e.fs = (c == 0) && (line == 0);
            end else begin
                e.x  = 7'(COLS - 1);
                e.hs = 1'b1;
            end
        end else begin
            e.x  = 7'(COLS - 1);
            e.y  = 7'(ROWS - 1);
            e.vs = 1'b1;
            e.fd = (k == FRAME_LEN - 1);
        end
`ifdef PIX_PATTERN_EN
        if (e.pv) e.pd = {e.x[3:0], e.y[3:0]} ^ e.fc;
`endif
        return e;
    endfunction

    initial begin
        vec_t vecs[FRAME_LEN];
        int   busy_n, pv_n, fs_n, fd_n;

        for (int k = 0; k < FRAME_LEN; k++) begin
            vecs[k].start = (k == 0) || (k == 7);
            vecs[k].cont  = (k == 10);
            vecs[k].stop  = 1'b0;
            vecs[k].exp   = exp_at(k, 0);
        end

        // Reset, with START held high to show it is ignored during reset
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("reset_state", observe(), '0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("idle_after_reset", observe(), '0);

        // Single frame, CONT=0, with a stray START while busy
        busy_n = 0;
        pv_n   = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            step(vecs[i].start, vecs[i].cont, vecs[i].stop);
            chk($sformatf("single_cyc%0d", i), observe(), vecs[i].exp);
            if (i == 15) chk("pix_x3y2_f0", pix_data, PD_X3Y2);
            busy_n += int'(busy);
            pv_n   += int'(pix_valid);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("single_idle_busy", busy, 1'b0);
        chk("single_frame_cnt", frame_cnt, 8'd1);
        chk("single_busy_cycles", busy_n, 21);
        chk("single_pix_valid_cycles", pv_n, 12);

        // Continuous: 3 frames, STOP at cycle 5 of frame 4; idle STOP beforehand is ignored
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("cont_reset_cnt", frame_cnt, 8'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("idle_stop_ignored", busy, 1'b0);
        fs_n = 0;
        fd_n = 0;
        for (int cyc = 0; cyc < 4 * FRAME_LEN; cyc++) begin
            step((cyc == 0) || (cyc == 30) || (cyc == 50),
                 !(cyc >= 10 && cyc < 15),
                 (cyc == 3 * FRAME_LEN + 5));
            chk($sformatf("cont_cyc%0d", cyc), observe(), exp_at(cyc % FRAME_LEN, cyc / FRAME_LEN));
            fs_n += int'(frame_start);
            fd_n += int'(frame_done);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("cont_stop_idle", busy, 1'b0);
        chk("cont_frame_cnt", frame_cnt, 8'd4);
        chk("cont_frame_starts", fs_n, 4);
        chk("cont_frame_dones", fd_n, 4);

        // START and STOP together with CONT=1: exactly one frame
        for (int k = 0; k < FRAME_LEN; k++) begin
            step(k == 0, 1'b1, k == 0);
            chk($sformatf("startstop_cyc%0d", k), observe(), exp_at(k, 4));
        end
        step(1'b0, 1'b1, 1'b0);
        chk("startstop_idle", busy, 1'b0);
        chk("startstop_frame_cnt", frame_cnt, 8'd5);
        chk("fw2_wrap", b2_fc, 2'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("startstop_stays_idle", busy, 1'b0);

        // Reset mid-frame at Y=1,X=2, then restart
        for (int k = 0; k <= LINE_LEN + 2; k++) begin
            step(k == 0, 1'b0, 1'b0);
            chk($sformatf("abort_cyc%0d", k), observe(), exp_at(k, 5));
        end
        chk("abort_point_xy", {y, x}, {7'd1, 7'd2});
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("abort_all_zero", observe(), '0);
        rst = 1'b0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            step(k == 0, 1'b0, 1'b0);
            chk($sformatf("restart_cyc%0d", k), observe(), exp_at(k, 0));
        end
        step(1'b0, 1'b0, 1'b0);
        chk("restart_frame_cnt", frame_cnt, 8'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
